line_window_cache: RTL

LINE_WINDOW_CACHE -- requirements
Module: line_window_cache

---
 rtl/line_window_cache.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/line_window_cache.sv
// line_window_cache
//   Four-slot line cache between a pixel-capture writer and a 3x3 window reader.
//   Line n of a frame lives in slot n mod 4. The reader walks lines one at a time
//   and sees the 3x3 neighbourhood around (rdLine, curPxl), two pxlClk cycles after
//   curPxl is presented.
//
// Parameters
//   LINE_W  pixels per line (up to 256, curPxl is 8 bits)
//   LINES   lines per frame
//
// Ports
//   pxlClk, rst                  clock and synchronous active-high reset
//   frameStart                   capture-side start-of-frame pulse
//   wrEn, wrRed/wrGreen/wrBlue   captured pixel strobe and colour
//   curPxl                       read column
//   nextLine, cacheUpdate        advance read line / reload slot pointers at line end
//   *Line*Pxl*Out                27 registered window colour outputs
//   sameLine                     reader may not advance yet
//   newFrameOut                  one-cycle pulse when a new frame becomes readable
//   overflow                     sticky: writer overran the reader
//
// Build option
//   LINE_WINDOW_EDGE_CLAMP_EN    defined: out-of-image neighbours replicate the nearest
//                                in-image pixel; undefined: they read as black.
module line_window_cache #(
    parameter int LINE_W = 240,
    parameter int LINES  = 160
) (
    input  logic       pxlClk,
    input  logic       rst,
    input  logic       frameStart,
    input  logic       wrEn,
    input  logic [7:0] wrRed,
    input  logic [7:0] wrGreen,
    input  logic [7:0] wrBlue,
    input  logic [7:0] curPxl,
    input  logic       nextLine,
    input  logic       cacheUpdate,
    output logic [7:0] prevLinePrevPxlRedOut, prevLinePrevPxlGreenOut, prevLinePrevPxlBlueOut,
    output logic [7:0] prevLineCurPxlRedOut,  prevLineCurPxlGreenOut,  prevLineCurPxlBlueOut,
    output logic [7:0] prevLineNextPxlRedOut, prevLineNextPxlGreenOut, prevLineNextPxlBlueOut,
    output logic [7:0] curLinePrevPxlRedOut,  curLinePrevPxlGreenOut,  curLinePrevPxlBlueOut,
    output logic [7:0] curLineCurPxlRedOut,   curLineCurPxlGreenOut,   curLineCurPxlBlueOut,
    output logic [7:0] curLineNextPxlRedOut,  curLineNextPxlGreenOut,  curLineNextPxlBlueOut,
    output logic [7:0] nextLinePrevPxlRedOut, nextLinePrevPxlGreenOut, nextLinePrevPxlBlueOut,
    output logic [7:0] nextLineCurPxlRedOut,  nextLineCurPxlGreenOut,  nextLineCurPxlBlueOut,
    output logic [7:0] nextLineNextPxlRedOut, nextLineNextPxlGreenOut, nextLineNextPxlBlueOut,
    output logic       sameLine,
    output logic       newFrameOut,
    output logic       overflow
);

    localparam int COL_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int LN_W  = $clog2(LINES + 1);
    localparam int RD_W  = (LINES > 1) ? $clog2(LINES) : 1;

`ifdef LINE_WINDOW_EDGE_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    logic [23:0]      line_mem [0:3][0:LINE_W-1];

    logic [COL_W-1:0] wrX_q, wrX_d;
    logic [LN_W-1:0]  linesDone_q, linesDone_d;
    logic [RD_W-1:0]  rdLine_q, rdLine_d;
    logic             newFrame_q, newFrame_d;
    logic             overflow_q, overflow_d;
    logic [1:0]       prevSlot_q, curSlot_q, nextSlot_q;
    logic             topEdge_q, botEdge_q;     // window line is first / last of frame
    logic             wrAccept, lineEnd, advanceOK;
    logic [31:0]      rdNeed;

    // ---------------- writer / read-line control ----------------
    always_comb begin
        rdNeed    = (32'(rdLine_q) + 32'd3 < LINES) ? 32'(rdLine_q) + 32'd3 : LINES;
        advanceOK = (32'(rdLine_q) < LINES - 1) && (32'(linesDone_q) >= rdNeed);

        wrAccept  = wrEn && !frameStart && (32'(linesDone_q) < LINES);
        lineEnd   = wrAccept && (wrX_q == COL_W'(LINE_W - 1));

        wrX_d       = wrX_q;
        linesDone_d = linesDone_q;
        if (frameStart) begin
            wrX_d       = '0;
            linesDone_d = '0;
        end else if (lineEnd) begin
            wrX_d       = '0;
            linesDone_d = linesDone_q + LN_W'(1);
        end else if (wrAccept) begin
            wrX_d = wrX_q + COL_W'(1);
        end

        // Completing line rdLine+3 or later reuses the slot the reader still needs.
        overflow_d = frameStart ? 1'b0 :
                     overflow_q || (lineEnd && (32'(linesDone_q) + 32'd1 > 32'(rdLine_q) + 32'd3));

        newFrame_d = lineEnd && (linesDone_q == LN_W'(1));

        rdLine_d = rdLine_q;
        if (newFrame_d)
            rdLine_d = '0;
        else if (nextLine && advanceOK)
            rdLine_d = rdLine_q + RD_W'(1);
    end

    assign sameLine    = !advanceOK;
    assign newFrameOut = newFrame_q;
    assign overflow    = overflow_q;

    always_ff @(posedge pxlClk) begin
        if (rst) begin
            wrX_q       <= '0;
            linesDone_q <= '0;
            rdLine_q    <= '0;
            newFrame_q  <= 1'b0;
            overflow_q  <= 1'b0;
            prevSlot_q  <= 2'd3;
            curSlot_q   <= 2'd0;
            nextSlot_q  <= 2'd1;
            topEdge_q   <= 1'b1;
            botEdge_q   <= (LINES == 1);
        end else begin
            wrX_q       <= wrX_d;
            linesDone_q <= linesDone_d;
            rdLine_q    <= rdLine_d;
            newFrame_q  <= newFrame_d;
            overflow_q  <= overflow_d;
            // Pointers only move at line end so the window never tears mid-line.
            if (cacheUpdate) begin
                prevSlot_q <= 2'(rdLine_d) - 2'd1;
                curSlot_q  <= 2'(rdLine_d);
                nextSlot_q <= 2'(rdLine_d) + 2'd1;
                topEdge_q  <= (rdLine_d == '0);
                botEdge_q  <= (32'(rdLine_d) == LINES - 1);
            end
        end
    end

    // Storage is never cleared; a write in a reset cycle is dropped.
    always_ff @(posedge pxlClk) begin
        if (wrAccept && !rst)
            line_mem[linesDone_q[1:0]][wrX_q] <= {wrRed, wrGreen, wrBlue};
    end

    // ---------------- stage 1: column addresses ----------------
    logic [COL_W-1:0] curClamp;
    logic [COL_W-1:0] col_q   [0:2];
    logic             colOk_q [0:2];

    always_comb begin
        curClamp = (32'(curPxl) >= LINE_W) ? COL_W'(LINE_W - 1) : COL_W'(curPxl);
    end

    // An out-of-image neighbour addresses the centre column: that is the replicated
    // pixel when clamping, and is masked to black otherwise.
    always_ff @(posedge pxlClk) begin
        if (rst) begin
            for (int c = 0; c < 3; c++) begin
                col_q[c]   <= '0;
                colOk_q[c] <= 1'b0;
            end
        end else begin
            col_q[0]   <= (curClamp != '0) ? curClamp - COL_W'(1) : curClamp;
            colOk_q[0] <= (curClamp != '0);
            col_q[1]   <= curClamp;
            colOk_q[1] <= 1'b1;
            col_q[2]   <= (curClamp != COL_W'(LINE_W - 1)) ? curClamp + COL_W'(1) : curClamp;
            colOk_q[2] <= (curClamp != COL_W'(LINE_W - 1));
        end
    end

    // ---------------- stage 2: registered read into window ----------------
    logic [1:0]  rowSlot [0:2];
    logic        rowOk   [0:2];
    logic [23:0] win_q   [0:2][0:2];

    always_comb begin
        rowSlot[0] = topEdge_q ? curSlot_q : prevSlot_q;
        rowSlot[1] = curSlot_q;
        rowSlot[2] = botEdge_q ? curSlot_q : nextSlot_q;
        rowOk[0]   = !topEdge_q || CLAMP;
        rowOk[1]   = 1'b1;
        rowOk[2]   = !botEdge_q || CLAMP;
    end

    always_ff @(posedge pxlClk) begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (rst || !(rowOk[r] && (colOk_q[c] || CLAMP)))
                    win_q[r][c] <= '0;
                else
                    win_q[r][c] <= line_mem[rowSlot[r]][col_q[c]];
            end
        end
    end

    assign {prevLinePrevPxlRedOut, prevLinePrevPxlGreenOut, prevLinePrevPxlBlueOut} = win_q[0][0];
    assign {prevLineCurPxlRedOut,  prevLineCurPxlGreenOut,  prevLineCurPxlBlueOut}  = win_q[0][1];
    assign {prevLineNextPxlRedOut, prevLineNextPxlGreenOut, prevLineNextPxlBlueOut} = win_q[0][2];
    assign {curLinePrevPxlRedOut,  curLinePrevPxlGreenOut,  curLinePrevPxlBlueOut}  = win_q[1][0];
    assign {curLineCurPxlRedOut,   curLineCurPxlGreenOut,   curLineCurPxlBlueOut}   = win_q[1][1];
    assign {curLineNextPxlRedOut,  curLineNextPxlGreenOut,  curLineNextPxlBlueOut}  = win_q[1][2];
    assign {nextLinePrevPxlRedOut, nextLinePrevPxlGreenOut, nextLinePrevPxlBlueOut} = win_q[2][0];
    assign {nextLineCurPxlRedOut,  nextLineCurPxlGreenOut,  nextLineCurPxlBlueOut}  = win_q[2][1];
    assign {nextLineNextPxlRedOut, nextLineNextPxlGreenOut, nextLineNextPxlBlueOut} = win_q[2][2];

endmodule
